// File: rtl/riscv_bitops_iter.sv
// riscv_bitops_iter
//   Multi-cycle bit-manipulation unit for the custom bitops extension.
//   It executes BITCOUNT, REVERSE, CLZ and CTZ on a WIDTH-bit operand.
//   It consumes CHUNK operand bits per cycle, LSB chunk first.
//   Every operation therefore takes exactly N = WIDTH/CHUNK cycles in BUSY.
//
// Ports
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   enable_i     request valid
//   ready_o      unit can accept a request (state == IDLE)
//   operator_i   00 BITCOUNT, 01 REVERSE, 10 CLZ, 11 CTZ
//   operand_i    source operand
//   flush_i      kills any in-flight or pending operation; highest priority
//   valid_o      result_o holds a completed result
//   ready_i      consumer accepts result
//   result_o     result (counts zero-extended)
//
// Handshakes
//   A request transfers on a posedge where enable_i && ready_o && !flush_i.
//   A result transfers on a posedge where valid_o && ready_i.
//   While valid_o is high and ready_i is low, valid_o and result_o stay stable.
//   flush_i on any edge returns the unit to IDLE and drops the request or result.
module riscv_bitops_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  output logic             ready_o,
  input  logic [1:0]       operator_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;   // shifted right by CHUNK each BUSY cycle
  logic [WIDTH-1:0] acc_q;    // running count or partially reversed word
  logic             found_q;  // CTZ: a set bit has been seen
  logic [CW-1:0]    cnt_q;

  logic [CHUNK-1:0] chunk;
  logic [WIDTH-1:0] acc_next;
  logic             found_next;

  assign chunk   = opnd_q[CHUNK-1:0];
  assign ready_o = (state == IDLE);

  function automatic logic [WIDTH-1:0] pop_chunk(input logic [CHUNK-1:0] c);
    logic [WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) n = n + WIDTH'(c[i]);
    return n;
  endfunction

  // Leading zeros inside one chunk; an all-zero chunk yields CHUNK.
  function automatic logic [WIDTH-1:0] lz_chunk(input logic [CHUNK-1:0] c);
    logic [WIDTH-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (c[i]) hit = 1'b1;
      else if (!hit) n = n + WIDTH'(1);
    end
    return n;
  endfunction

  // Trailing zeros inside one chunk; an all-zero chunk yields CHUNK.
  function automatic logic [WIDTH-1:0] tz_chunk(input logic [CHUNK-1:0] c);
    logic [WIDTH-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (c[i]) hit = 1'b1;
      else if (!hit) n = n + WIDTH'(1);
    end
    return n;
  endfunction

  function automatic logic [CHUNK-1:0] rev_chunk(input logic [CHUNK-1:0] c);
    logic [CHUNK-1:0] r;
    for (int i = 0; i < CHUNK; i++) r[i] = c[CHUNK-1-i];
    return r;
  endfunction

  // One chunk step. Chunks arrive LSB first.
  // REVERSE: shifting left and inserting each reversed chunk at the bottom
  //   leaves the first (lowest) chunk at the top after N steps.
  // CLZ: the acc holds the leading zeros of the bits seen so far.
  //   A non-zero higher chunk restarts the count.
  //   A zero higher chunk adds CHUNK.
  // CTZ: the acc counts until the first set bit, then freezes.
  always_comb begin
    acc_next   = acc_q;
    found_next = found_q;
    case (op_q)
      2'b00: acc_next = acc_q + pop_chunk(chunk);
      2'b01: acc_next = (acc_q << CHUNK) | WIDTH'(rev_chunk(chunk));
      2'b10: acc_next = (chunk != '0) ? lz_chunk(chunk) : acc_q + WIDTH'(CHUNK);
      default: begin
        if (!found_q) begin
          acc_next   = acc_q + tz_chunk(chunk);
          found_next = (chunk != '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid_o  <= 1'b0;
      result_o <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      found_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i && !flush_i) begin
            state   <= BUSY;
            op_q    <= operator_i;
            opnd_q  <= operand_i;
            acc_q   <= '0;
            found_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (flush_i) begin
            state <= IDLE;
            cnt_q <= '0;
          end else begin
            acc_q   <= acc_next;
            found_q <= found_next;
            opnd_q  <= opnd_q >> CHUNK;
            if (cnt_q == CW'(N - 1)) begin
              state    <= DONE;
              cnt_q    <= '0;
              valid_o  <= 1'b1;
              result_o <= acc_next;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          if (flush_i || ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_bitops_iter.sv
module tb_riscv_bitops_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        en_aux = 1'b0;
  logic [1:0]  operator = 2'b00;
  logic [31:0] operand = '0;
  logic        flush = 1'b0;
  logic        ready_i = 1'b0;
  logic        rdy_aux = 1'b0;

  logic        ready_o, valid_o;
  logic [31:0] result_o;
  logic        ready_c1, valid_c1, ready_c8, valid_c8;
  logic [31:0] result_c1, result_c8;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_bitops_iter #(.WIDTH(32), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .enable_i(enable), .ready_o(ready_o),
    .operator_i(operator), .operand_i(operand), .flush_i(flush),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o));

  riscv_bitops_iter #(.WIDTH(32), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .enable_i(en_aux), .ready_o(ready_c1),
    .operator_i(operator), .operand_i(operand), .flush_i(flush),
    .valid_o(valid_c1), .ready_i(rdy_aux), .result_o(result_c1));

  riscv_bitops_iter #(.WIDTH(32), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .enable_i(en_aux), .ready_o(ready_c8),
    .operator_i(operator), .operand_i(operand), .flush_i(flush),
    .valid_o(valid_c8), .ready_i(rdy_aux), .result_o(result_c8));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] exp;
    string       name;
  } vec_t;

  // Reference model computed directly from the operator definitions.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a);
    logic [31:0] r;
    int n;
    r = '0;
    n = 0;
    case (op)
      2'd0: r = 32'($countones(a));
      2'd1: for (int i = 0; i < 32; i++) r[i] = a[31-i];
      2'd2: begin
        while (n < 32 && !a[31-n]) n++;
        r = 32'(n);
      end
      default: begin
        while (n < 32 && !a[n]) n++;
        r = 32'(n);
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for valid_o of the main instance; returns cycles after accept.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] exp, input string nm);
    int lat;
    logic [31:0] e;
    @(negedge clk);
    chk({nm, " ready_before"}, 32'(ready_o), 32'd1);
    operator = op;
    operand  = a;
    enable   = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    enable   = 1'b0;
    operand  = $urandom();
    operator = 2'($urandom_range(0, 3));
    wait_valid(lat);
    chk({nm, " latency"}, 32'(lat), 32'd8);
    e = exp_q.pop_front();
    chk({nm, " result"}, result_o, e);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({nm, " valid_after_hs"}, 32'(valid_o), 32'd0);
    chk({nm, " result_kept"}, result_o, e);
  endtask

  // Drives one request into both aux instances (CHUNK=1 and CHUNK=8) and
  // measures their latencies. It returns right after the result handshake,
  // so a following call requests on the very next edge.
  task automatic aux_pair(input logic [1:0] op, input logic [31:0] a, input string nm);
    int l1, l8;
    logic [31:0] e;
    e = model(op, a);
    operator = op;
    operand  = a;
    en_aux   = 1'b1;
    @(posedge clk); #1;
    en_aux = 1'b0;
    chk({nm, " c1_accepted"}, 32'(ready_c1), 32'd0);
    chk({nm, " c8_accepted"}, 32'(ready_c8), 32'd0);
    l1 = -1;
    l8 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid_c8 && l8 < 0) l8 = k;
      if (valid_c1 && l1 < 0) l1 = k;
      if (l1 >= 0 && l8 >= 0) break;
    end
    chk({nm, " c1_latency"}, 32'(l1), 32'd32);
    chk({nm, " c8_latency"}, 32'(l8), 32'd4);
    chk({nm, " c1_result"}, result_c1, e);
    chk({nm, " c8_result"}, result_c8, e);
    rdy_aux = 1'b1;
    @(posedge clk); #1;
    rdy_aux = 1'b0;
    chk({nm, " aux_valid_drop"}, 32'({valid_c1, valid_c8}), 32'd0);
  endtask

  initial begin
    vec_t vecs[$];
    int lat;
    int seen;
    logic [1:0] rop;
    logic [31:0] ra;

    vecs.push_back('{2'd0, 32'hF0F0_00FF, 32'h0000_0010, "bitcount_f0f000ff"});
    vecs.push_back('{2'd0, 32'h0000_0000, 32'h0000_0000, "bitcount_zero"});
    vecs.push_back('{2'd0, 32'hFFFF_FFFF, 32'h0000_0020, "bitcount_ones"});
    vecs.push_back('{2'd1, 32'h0000_0001, 32'h8000_0000, "reverse_1"});
    vecs.push_back('{2'd1, 32'h1234_5678, 32'h1E6A_2C48, "reverse_12345678"});
    vecs.push_back('{2'd2, 32'h0000_0000, 32'h0000_0020, "clz_zero"});
    vecs.push_back('{2'd2, 32'h0001_0000, 32'h0000_000F, "clz_bit16"});
    vecs.push_back('{2'd2, 32'h8000_0000, 32'h0000_0000, "clz_msb"});
    vecs.push_back('{2'd3, 32'h0000_0000, 32'h0000_0020, "ctz_zero"});
    vecs.push_back('{2'd3, 32'h8000_0000, 32'h0000_001F, "ctz_msb"});
    vecs.push_back('{2'd3, 32'h0000_0001, 32'h0000_0000, "ctz_lsb"});
    vecs.push_back('{2'd3, 32'h0000_0030, 32'h0000_0004, "ctz_bit4"});

    // Reset
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset ready_o", 32'(ready_o), 32'd1);
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset result_o", result_o, 32'd0);
    chk("reset aux", 32'({ready_c1, ready_c8, valid_c1, valid_c8}), 32'b1100);

    // Directed table
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].exp, vecs[i].name);

    // Randomized against the model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom();
      if (i % 3 == 1) ra = ra >> $urandom_range(0, 31);
      if (i % 3 == 2) ra = ra << $urandom_range(0, 31);
      run_op(rop, ra, model(rop, ra), "random");
    end

    // Backpressure; enable held high during BUSY and DONE must be ignored.
    @(negedge clk);
    operator = 2'd0;
    operand  = 32'h0F0F_0F0F;
    enable   = 1'b1;
    @(posedge clk); #1;
    operator = 2'd1;
    operand  = 32'hFFFF_FFFF;
    wait_valid(lat);
    chk("bp latency", 32'(lat), 32'd8);
    chk("bp result", result_o, 32'd16);
    for (int k = 0; k < 5; k++) begin
      operand = $urandom();
      @(posedge clk); #1;
      chk("bp valid_held", 32'(valid_o), 32'd1);
      chk("bp result_held", result_o, 32'd16);
      chk("bp ready_low", 32'(ready_o), 32'd0);
    end
    enable  = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("bp ready_after_hs", 32'(ready_o), 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid_o || !ready_o) seen++;
    end
    chk("bp not_queued", 32'(seen), 32'd0);

    // Back-to-back on the main instance: enable right after the handshake.
    run_op(2'd1, 32'h0000_0001, 32'h8000_0000, "pre_b2b");
    operator = 2'd0;
    operand  = 32'h0000_00FF;
    enable   = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    chk("b2b accepted", 32'(ready_o), 32'd0);
    wait_valid(lat);
    chk("b2b latency", 32'(lat), 32'd8);
    chk("b2b result", result_o, 32'd8);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;

    // Flush at BUSY cycle 3
    @(negedge clk);
    operator = 2'd1;
    operand  = 32'hDEAD_BEEF;
    enable   = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("flush busy_before", 32'(ready_o), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush ready", 32'(ready_o), 32'd1);
    chk("flush valid", 32'(valid_o), 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    chk("flush no_valid", 32'(seen), 32'd0);

    // Flush together with enable in IDLE: not accepted
    @(negedge clk);
    enable = 1'b1;
    flush  = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    flush  = 1'b0;
    chk("flush_idle ready", 32'(ready_o), 32'd1);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (valid_o || !ready_o) seen++;
    end
    chk("flush_idle no_accept", 32'(seen), 32'd0);

    // Flush in DONE drops the result
    @(negedge clk);
    operator = 2'd2;
    operand  = 32'h0000_0100;
    enable   = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    wait_valid(lat);
    chk("flush_done result", result_o, 32'd23);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done valid", 32'(valid_o), 32'd0);
    chk("flush_done ready", 32'(ready_o), 32'd1);

    // Healthy after the flushes, and leaves a non-zero result behind.
    run_op(2'd1, 32'h0000_0003, 32'hC000_0000, "post_flush");

    // Reset mid-operation
    @(negedge clk);
    operator = 2'd0;
    operand  = 32'hFFFF_0000;
    enable   = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid ready", 32'(ready_o), 32'd1);
    chk("rst_mid valid", 32'(valid_o), 32'd0);
    chk("rst_mid result", result_o, 32'd0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (valid_o) seen++;
    end
    chk("rst_mid no_valid", 32'(seen), 32'd0);

    // CHUNK=1 and CHUNK=8 latency, back-to-back
    @(negedge clk);
    aux_pair(2'd0, 32'hF0F0_00FF, "aux_bitcount");
    aux_pair(2'd1, 32'h1234_5678, "aux_reverse");
    aux_pair(2'd2, 32'h0001_0000, "aux_clz");
    aux_pair(2'd3, 32'h0000_0000, "aux_ctz");
    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom() >> $urandom_range(0, 31);
      aux_pair(rop, ra, "aux_random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
